nibble_add_sched: RTL and testbench

- Controller that shares one external 4-bit ripple adder (sum/cout slice) between two requesters.
- Performs WIDTH-bit additions by sequencing the adder nibble-serially, LSB first, with a registered carry chain.
- Arbitrates round-robin between the requesters and returns each result on a valid/ready response channel.
- Sits between the ALU issue logic and the shared adder instance in the datapath.

---
 rtl/nibble_add_sched.sv | 153 +++++++++++++++
 tb/tb_nibble_add_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_sched.sv
// ============================================================================
// Module   : nibble_add_sched
// Brief    : Round-robin scheduler that time-shares one external 4-bit adder
//            slice to perform WIDTH-bit additions nibble-serially, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_add_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic [3:0]       adder_a,
    output logic [3:0]       adder_b,
    output logic             adder_cin,
    input  logic [3:0]       adder_sum,
    input  logic             adder_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf
);

    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] C_LAST_K = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic             r_cin;
    logic             r_id;
    logic             r_last;
    logic             r_cout;
    logic             r_ovf;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;

    logic             w_grant;
    logic             w_accept;
    logic             w_last_slice;
    logic             w_hs;
    logic [KW+1:0]    w_base;

    // Contention goes to whichever requester was not served last.
    always_comb begin
        w_grant      = (req0_valid && req1_valid) ? ~r_last : req1_valid;
        w_accept     = (r_state == S_IDLE) && (req0_valid || req1_valid);
        req0_ready   = (r_state == S_IDLE) && req0_valid && !w_grant;
        req1_ready   = (r_state == S_IDLE) && req1_valid && w_grant;
        w_last_slice = (r_k == C_LAST_K);
        w_base       = {r_k, 2'b00};
        w_hs         = (r_state == S_DONE) && rsp_ready;
    end

    always_comb begin
        adder_a   = 4'd0;
        adder_b   = 4'd0;
        adder_cin = 1'b0;
        if (r_state == S_RUN) begin
            adder_a   = r_a[w_base +: 4];
            adder_b   = r_b[w_base +: 4];
            adder_cin = (r_k == '0) ? r_cin : r_carry;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_last_slice) w_next = S_DONE;
            S_DONE:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_cin   <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_grant ? req1_a   : req0_a;
                        r_b     <= w_grant ? req1_b   : req0_b;
                        r_cin   <= w_grant ? req1_cin : req0_cin;
                        r_id    <= w_grant;
                        r_k     <= '0;
                        r_carry <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_res[w_base +: 4] <= adder_sum;
                    r_carry            <= adder_cout;
                    if (w_last_slice) begin
                        r_k    <= '0;
                        r_cout <= adder_cout;
                        // Overflow: like-signed operands producing an opposite-signed result.
                        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                  (adder_sum[3] != r_a[WIDTH-1]);
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_DONE: begin
                    if (w_hs) r_last <= r_id;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (r_state == S_DONE);
    assign rsp_id    = r_id;
    assign rsp_sum   = r_res;
    assign rsp_cout  = r_cout;
    assign rsp_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_nibble_add_sched.sv
// ============================================================================
// Module   : tb_nibble_add_sched
// Brief    : Self-checking bench for nibble_add_sched with an arithmetic model
//            and a behavioural stand-in for the shared 4-bit adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_add_sched;

    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic [3:0]   adder_a, adder_b, adder_sum;
    logic         adder_cin, adder_cout;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
    logic [W-1:0] rsp_sum;

    int checks = 0;
    int errors = 0;

    nibble_add_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_cin(req1_cin),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_sum(adder_sum), .adder_cout(adder_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
    );

    // The shared external adder slice.
    assign {adder_cout, adder_sum} = 5'(adder_a) + 5'(adder_b) + 5'(adder_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit           m_idle, m_done, m_last, m_cin, m_id;
    int           m_k;
    logic [W-1:0] m_A, m_B;
    logic [W-1:0] e_sum;
    bit           e_cout, e_ovf, e_id;

    function automatic bit m_grant(input bit v0, input bit v1);
        return (v0 && v1) ? !m_last : v1;
    endfunction

    task automatic model_reset();
        m_idle = 1; m_done = 0; m_last = 1; m_k = -1;
        m_A = '0; m_B = '0; m_cin = 0; m_id = 0;
        e_sum = '0; e_cout = 0; e_ovf = 0; e_id = 0;
    endtask

    task automatic model_step();
        bit          g;
        logic [W:0]  s;
        if (!rst_n) begin
            model_reset();
        end else if (m_idle) begin
            if (req0_valid || req1_valid) begin
                g     = m_grant(req0_valid, req1_valid);
                m_id  = g;
                m_A   = g ? req1_a : req0_a;
                m_B   = g ? req1_b : req0_b;
                m_cin = g ? req1_cin : req0_cin;
                m_idle = 0;
                m_k    = 0;
            end
        end else if (m_k >= 0) begin
            if (m_k == NS - 1) begin
                s      = (W+1)'(m_A) + (W+1)'(m_B) + (W+1)'(m_cin);
                e_sum  = s[W-1:0];
                e_cout = s[W];
                e_ovf  = (m_A[W-1] == m_B[W-1]) && (s[W-1] != m_A[W-1]);
                e_id   = m_id;
                m_k    = -1;
                m_done = 1;
            end else begin
                m_k++;
            end
        end else if (m_done && rsp_ready) begin
            m_done = 0;
            m_idle = 1;
            m_last = e_id;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        bit          g;
        logic [31:0] mask, ea, eb, ec;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                g = m_grant(req0_valid, req1_valid);
                chk("req0_ready", req0_ready, m_idle && req0_valid && !g);
                chk("req1_ready", req1_ready, m_idle && req1_valid && g);
                if (m_k >= 0) begin
                    mask = (32'd1 << (4 * m_k)) - 32'd1;
                    ea   = (32'(m_A) >> (4 * m_k)) & 32'hF;
                    eb   = (32'(m_B) >> (4 * m_k)) & 32'hF;
                    ec   = (((32'(m_A) & mask) + (32'(m_B) & mask) + 32'(m_cin)) >> (4 * m_k)) & 32'd1;
                end else begin
                    ea = 0; eb = 0; ec = 0;
                end
                chk("adder_a", adder_a, ea);
                chk("adder_b", adder_b, eb);
                chk("adder_cin", adder_cin, ec);
                chk("rsp_valid", rsp_valid, m_done);
                if (m_done || m_idle) begin
                    chk("rsp_sum", rsp_sum, e_sum);
                    chk("rsp_cout", rsp_cout, e_cout);
                    chk("rsp_ovf", rsp_ovf, e_ovf);
                    chk("rsp_id", rsp_id, e_id);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [3:0] cap_a [NS];
    logic       cap_cin [NS];

    task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit cin, input logic [W-1:0] xs, input bit xc, input bit xo);
        bit seen;
        @(posedge clk); #1;
        if (id) begin req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1; end
        else    begin req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1; end
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = id ? req1_ready : req0_ready;
        end
        if (!seen) timeout("accept");
        @(posedge clk); #1;
        // Operands change after accept and must not affect the result.
        if (id) begin req1_valid = 0; req1_a = 16'hDEAD; req1_b = 16'hBEEF; req1_cin = ~cin; end
        else    begin req0_valid = 0; req0_a = 16'hDEAD; req0_b = 16'hBEEF; req0_cin = ~cin; end
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            cap_a[k]   = adder_a;
            cap_cin[k] = adder_cin;
        end
        @(negedge clk);
        chk("lit_rsp_valid", rsp_valid, 1);
        chk("lit_rsp_sum", rsp_sum, xs);
        chk("lit_rsp_cout", rsp_cout, xc);
        chk("lit_rsp_ovf", rsp_ovf, xo);
        chk("lit_rsp_id", rsp_id, id);
    endtask

    initial begin
        int gid [$];
        int gcyc [$];
        int cyc;
        rst_n = 0; rsp_ready = 1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_sum", rsp_sum, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_adder_a", adder_a, 0);

        do_op(0, 16'h1234, 16'h4321, 0, 16'h5555, 0, 0);
        chk("seq_adder_a", {cap_a[0], cap_a[1], cap_a[2], cap_a[3]}, 16'h4321);

        do_op(1, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0);
        chk("seq_adder_cin", {cap_cin[0], cap_cin[1], cap_cin[2], cap_cin[3]}, 4'b0111);

        do_op(0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
        do_op(1, 16'h8000, 16'h8000, 1, 16'h0001, 1, 1);

        // Backpressure: hold the response for 10 cycles with both requesters waiting.
        @(posedge clk); #1 rsp_ready = 0;
        do_op(0, 16'h0F0F, 16'h0101, 1, 16'h1011, 0, 0);
        @(posedge clk); #1 req0_valid = 1; req1_valid = 1;
        req1_a = 16'h0002; req1_b = 16'h0003; req1_cin = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_sum", rsp_sum, 16'h1011);
            chk("bp_ready", {req0_ready, req1_ready}, 2'b00);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk);
        chk("bp_hs_valid", rsp_valid, 1);
        @(negedge clk);
        chk("bp_after_valid", rsp_valid, 0);
        chk("bp_after_req1_ready", {req0_ready, req1_ready}, 2'b01);
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        repeat (8) @(negedge clk);

        // Reset during RUN slice 2.
        @(posedge clk); #1 req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 0; req0_valid = 1;
        @(negedge clk);
        chk("rst_op_accept", req0_ready, 1);
        @(posedge clk); #1 req0_valid = 0;
        repeat (3) @(negedge clk);
        chk("rst_slice2_a", adder_a, 2);
        #2 rst_n = 0;
        #1;
        chk("rst_now_valid", rsp_valid, 0);
        chk("rst_now_adder", {adder_a, adder_b, 3'b000, adder_cin}, 0);
        req0_valid = 1; req1_valid = 1;
        req0_a = 16'h0011; req0_b = 16'h0022; req1_a = 16'h0100; req1_b = 16'h0200;
        @(posedge clk); #1 rst_n = 1;

        // Continuous contention: grants must alternate every NS+2 cycles.
        cyc = 0;
        while (gid.size() < 4 && cyc < 40) begin
            @(negedge clk);
            if (req0_ready) begin gid.push_back(0); gcyc.push_back(cyc); end
            if (req1_ready) begin gid.push_back(1); gcyc.push_back(cyc); end
            cyc++;
        end
        if (gid.size() < 4) timeout("arb_grants");
        else begin
            chk("arb_ids", {gid[0][0], gid[1][0], gid[2][0], gid[3][0]}, 4'b0101);
            for (int i = 1; i < 4; i++)
                chk("arb_interval", gcyc[i] - gcyc[i-1], NS + 2);
        end
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
